// File: rtl/exec_sequencer_pkg.sv
// Shared encodings for the execution sequencer: opcodes, states,
// writeback select and the wait-state timeout.
package seq_pkg;

  localparam int TIMEOUT = 15;

  localparam logic [5:0] OP_ALU_LAST = 6'd17;
  localparam logic [5:0] OP_CTL_18   = 6'd18;
  localparam logic [5:0] OP_CTL_19   = 6'd19;
  localparam logic [5:0] OP_INP      = 6'd26;
  localparam logic [5:0] OP_OUTP     = 6'd27;
  localparam logic [5:0] OP_PUSH     = 6'd28;
  localparam logic [5:0] OP_POP      = 6'd29;
  localparam logic [5:0] OP_BRZ      = 6'd32;
  localparam logic [5:0] OP_BRN      = 6'd33;
  localparam logic [5:0] OP_BRC      = 6'd34;
  localparam logic [5:0] OP_BRO      = 6'd35;
  localparam logic [5:0] OP_BRA      = 6'd36;
  localparam logic [5:0] OP_JMP      = 6'd37;
  localparam logic [5:0] OP_RET      = 6'd38;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_ALU_WAIT  = 3'd2,
    ST_PUSH_WAIT = 3'd3,
    ST_POP_WAIT  = 3'd4,
    ST_COMMIT    = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_POP = 2'd1,
    WB_IMM = 2'd2
  } wb_sel_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_PUSH,
    CLS_POP,
    CLS_DIRECT,
    CLS_ILLEGAL
  } op_class_t;

  // Which path through the sequencer an opcode takes.
  function automatic op_class_t classify(input logic [5:0] op);
    op_class_t cls;
    cls = CLS_ILLEGAL;
    if (op <= OP_ALU_LAST) begin
      cls = CLS_ALU;
    end else begin
      case (op)
        OP_PUSH, OP_JMP: cls = CLS_PUSH;
        OP_POP, OP_RET:  cls = CLS_POP;
        OP_CTL_18, OP_CTL_19, OP_INP, OP_OUTP,
        OP_BRZ, OP_BRN, OP_BRC, OP_BRO, OP_BRA: cls = CLS_DIRECT;
        default: cls = CLS_ILLEGAL;
      endcase
    end
    return cls;
  endfunction

  // Branch condition against the ALU flags seen in DECODE.
  function automatic logic branch_taken(input logic [5:0] op,
                                        input logic z, input logic n,
                                        input logic c, input logic v);
    logic taken;
    taken = 1'b0;
    case (op)
      OP_BRZ:         taken = z;
      OP_BRN:         taken = n;
      OP_BRC:         taken = c;
      OP_BRO:         taken = v;
      OP_BRA, OP_JMP: taken = 1'b1;
      default:        taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Fetch, ALU, stack, writeback and PC signals of the execution sequencer.
// master = surrounding datapath/testbench, slave = sequencer.
interface exec_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instruction;
  logic [9:0]  pc;
  logic [15:0] imm;
  logic        fl_zero;
  logic        fl_negative;
  logic        fl_carry;
  logic        fl_overflow;
  logic        alu_enable;
  logic        alu_done;
  logic        push_req;
  logic [15:0] push_data;
  logic        push_done;
  logic        pop_req;
  logic        pop_done;
  logic [15:0] pop_out;
  logic        wb_en;
  logic [1:0]  wb_sel;
  logic        pc_load;
  logic [9:0]  pc_out;
  logic        busy;
  logic        err_timeout;
  logic        err_illegal;

  modport master (
    output instr_valid, instruction, pc, imm,
    output fl_zero, fl_negative, fl_carry, fl_overflow,
    output alu_done, push_done, pop_done, pop_out,
    input  instr_ready, alu_enable, push_req, push_data, pop_req,
    input  wb_en, wb_sel, pc_load, pc_out, busy, err_timeout, err_illegal
  );

  modport slave (
    input  instr_valid, instruction, pc, imm,
    input  fl_zero, fl_negative, fl_carry, fl_overflow,
    input  alu_done, push_done, pop_done, pop_out,
    output instr_ready, alu_enable, push_req, push_data, pop_req,
    output wb_en, wb_sel, pc_load, pc_out, busy, err_timeout, err_illegal
  );
endinterface

// File: rtl/exec_sequencer_wait_timer.sv
// Wait-state timer: down-counter reloaded while not waiting; expired marks
// the edge that would complete the TIMEOUT-th wait cycle.
module wait_timer
  import seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [3:0] count;

  // Reload on clear, otherwise count down once per enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 4'd0;
    end else if (clear) begin
      count <= 4'(TIMEOUT);
    end else if (enable && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign expired = (count == 4'd1);

endmodule

// File: rtl/exec_sequencer.sv
// Execution sequencer: accepts one instruction, routes it through the ALU,
// stack push or stack pop handshake, then commits writeback and next PC.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | instr_ready high, waiting for instr_valid
// ST_DECODE    | opcode classified, flags sampled, alu_enable pulse
// ST_ALU_WAIT  | waiting for alu_done
// ST_PUSH_WAIT | push_req held, waiting for push_done (PUSH, JMP)
// ST_POP_WAIT  | pop_req held, waiting for pop_done (POP, RET)
// ST_COMMIT    | one cycle: pc_load, optional wb_en, error pulses
module exec_sequencer
  import seq_pkg::*;
(
  input logic             clk,
  input logic             rst_b,
  exec_sequencer_if.slave bus
);

  seq_state_t  state;
  logic [5:0]  opcode_q;
  logic [9:0]  pc_q;
  logic [15:0] imm_q;
  logic [15:0] pop_q;
  logic [9:0]  pc_inc;

  logic        instr_ready_q;
  logic        busy_q;
  logic        alu_enable_q;
  logic        push_req_q;
  logic [15:0] push_data_q;
  logic        pop_req_q;
  logic        wb_en_q;
  wb_sel_t     wb_sel_q;
  logic        pc_load_q;
  logic [9:0]  pc_out_q;
  logic        err_timeout_q;
  logic        err_illegal_q;

  logic        waiting;
  logic        timer_expired;

  assign pc_inc  = pc_q + 10'd1;
  assign waiting = (state == ST_ALU_WAIT) || (state == ST_PUSH_WAIT) ||
                   (state == ST_POP_WAIT);

  wait_timer u_wait_timer (
    .clk     (clk),
    .rst     (rst_b),
    .clear   (!waiting),
    .enable  (waiting),
    .expired (timer_expired)
  );

  // Sequencer FSM; all outputs registered, pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state         <= ST_IDLE;
      opcode_q      <= '0;
      pc_q          <= '0;
      imm_q         <= '0;
      pop_q         <= '0;
      instr_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      alu_enable_q  <= 1'b0;
      push_req_q    <= 1'b0;
      push_data_q   <= '0;
      pop_req_q     <= 1'b0;
      wb_en_q       <= 1'b0;
      wb_sel_q      <= WB_ALU;
      pc_load_q     <= 1'b0;
      pc_out_q      <= '0;
      err_timeout_q <= 1'b0;
      err_illegal_q <= 1'b0;
    end else begin
      alu_enable_q  <= 1'b0;
      wb_en_q       <= 1'b0;
      wb_sel_q      <= WB_ALU;
      pc_load_q     <= 1'b0;
      pc_out_q      <= '0;
      err_timeout_q <= 1'b0;
      err_illegal_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (bus.instr_valid) begin
            opcode_q      <= bus.instruction[15:10];
            pc_q          <= bus.pc;
            imm_q         <= bus.imm;
            // The start pulse has to be visible during DECODE itself.
            alu_enable_q  <= (classify(bus.instruction[15:10]) == CLS_ALU);
            instr_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            state         <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          case (classify(opcode_q))
            CLS_ALU: state <= ST_ALU_WAIT;
            CLS_PUSH: begin
              push_req_q  <= 1'b1;
              push_data_q <= (opcode_q == OP_PUSH) ? imm_q : {6'd0, pc_inc};
              state       <= ST_PUSH_WAIT;
            end
            CLS_POP: begin
              pop_req_q <= 1'b1;
              state     <= ST_POP_WAIT;
            end
            CLS_DIRECT: begin
              pc_load_q <= 1'b1;
              pc_out_q  <= branch_taken(opcode_q, bus.fl_zero, bus.fl_negative,
                                        bus.fl_carry, bus.fl_overflow)
                           ? imm_q[9:0] : pc_inc;
              if (opcode_q == OP_INP) begin
                wb_en_q  <= 1'b1;
                wb_sel_q <= WB_IMM;
              end
              state <= ST_COMMIT;
            end
            default: begin
              pc_load_q     <= 1'b1;
              pc_out_q      <= pc_inc;
              err_illegal_q <= 1'b1;
              state         <= ST_COMMIT;
            end
          endcase
        end

        ST_ALU_WAIT: begin
          if (bus.alu_done) begin
            pc_load_q <= 1'b1;
            pc_out_q  <= pc_inc;
            wb_en_q   <= 1'b1;
            wb_sel_q  <= WB_ALU;
            state     <= ST_COMMIT;
          end else if (timer_expired) begin
            pc_load_q     <= 1'b1;
            pc_out_q      <= pc_inc;
            err_timeout_q <= 1'b1;
            state         <= ST_COMMIT;
          end
        end

        ST_PUSH_WAIT: begin
          if (bus.push_done) begin
            push_req_q <= 1'b0;
            pc_load_q  <= 1'b1;
            pc_out_q   <= (opcode_q == OP_JMP) ? imm_q[9:0] : pc_inc;
            state      <= ST_COMMIT;
          end else if (timer_expired) begin
            // A call whose return address never landed does not jump.
            push_req_q    <= 1'b0;
            pc_load_q     <= 1'b1;
            pc_out_q      <= pc_inc;
            err_timeout_q <= 1'b1;
            state         <= ST_COMMIT;
          end
        end

        ST_POP_WAIT: begin
          if (bus.pop_done) begin
            pop_req_q <= 1'b0;
            pop_q     <= bus.pop_out;
            pc_load_q <= 1'b1;
            if (opcode_q == OP_RET) begin
              pc_out_q <= bus.pop_out[9:0];
            end else begin
              pc_out_q <= pc_inc;
              wb_en_q  <= 1'b1;
              wb_sel_q <= WB_POP;
            end
            state <= ST_COMMIT;
          end else if (timer_expired) begin
            pop_req_q     <= 1'b0;
            pc_load_q     <= 1'b1;
            pc_out_q      <= pc_inc;
            err_timeout_q <= 1'b1;
            state         <= ST_COMMIT;
          end
        end

        ST_COMMIT: begin
          instr_ready_q <= 1'b1;
          busy_q        <= 1'b0;
          state         <= ST_IDLE;
        end

        default: begin
          push_req_q    <= 1'b0;
          pop_req_q     <= 1'b0;
          instr_ready_q <= 1'b1;
          busy_q        <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

  // Operand field of the instruction is consumed by the datapath, not here;
  // the popped word is held for observation, only its low bits steer the PC.
  logic unused_bits;
  assign unused_bits = ^{bus.instruction[9:0], pop_q};

  assign bus.instr_ready = instr_ready_q;
  assign bus.busy        = busy_q;
  assign bus.alu_enable  = alu_enable_q;
  assign bus.push_req    = push_req_q;
  assign bus.push_data   = push_data_q;
  assign bus.pop_req     = pop_req_q;
  assign bus.wb_en       = wb_en_q;
  assign bus.wb_sel      = wb_sel_q;
  assign bus.pc_load     = pc_load_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_illegal = err_illegal_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: a timeline model predicts every output
// cycle from the opcode rules; a negedge process compares against it.
module tb_exec_sequencer;

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  exec_sequencer_if bus();

  exec_sequencer dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       alu_en;
    logic       push_req;
    logic       pop_req;
    logic       wb_en;
    logic [1:0] wb_sel;
    logic       pc_load;
    logic [9:0] pc_out;
    logic       err_to;
    logic       err_ill;
  } obs_t;

  typedef struct {
    obs_t        o;
    logic [15:0] pd;
  } step_t;

  step_t exp_q[$];
  step_t tl_q[$];
  int    w_model;
  int    total = 0;
  int    bad = 0;
  bit    chk_en = 1'b0;
  int    last_pc, last_wb, last_wbsel, last_pd, last_to, last_ill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected output timeline for one instruction: DECODE, wait cycles, COMMIT.
  // d = cycles until done is sampled high in the wait state (0 = never).
  function automatic void build(input logic [5:0] op, input logic [9:0] pc,
                                input logic [15:0] imm, input logic [3:0] flg,
                                input int d, input logic [15:0] popv);
    int    opi, nxt, tgt;
    bit    alu, push, pop, direct, waits, to;
    step_t s;
    opi    = int'(op);
    alu    = (opi <= 17);
    push   = (opi == 28) || (opi == 37);
    pop    = (opi == 29) || (opi == 38);
    direct = (opi == 18) || (opi == 19) || (opi == 26) || (opi == 27) ||
             ((opi >= 32) && (opi <= 36));
    waits  = alu || push || pop;
    to     = waits && (d == 0);
    nxt    = (int'(pc) + 1) % 1024;
    tgt    = nxt;
    w_model = waits ? (to ? 15 : d) : 0;
    if (!to) begin
      case (opi)
        32: if (flg[3]) tgt = int'(imm) % 1024;
        33: if (flg[2]) tgt = int'(imm) % 1024;
        34: if (flg[1]) tgt = int'(imm) % 1024;
        35: if (flg[0]) tgt = int'(imm) % 1024;
        36, 37: tgt = int'(imm) % 1024;
        38: tgt = int'(popv) % 1024;
        default: ;
      endcase
    end
    tl_q.delete();
    s.o = '0; s.pd = '0;
    s.o.busy = 1'b1; s.o.alu_en = alu;
    tl_q.push_back(s);
    for (int i = 0; i < w_model; i++) begin
      s.o = '0;
      s.o.busy = 1'b1; s.o.push_req = push; s.o.pop_req = pop;
      s.pd = (opi == 28) ? imm : 16'(nxt);
      tl_q.push_back(s);
    end
    s.o = '0; s.pd = '0;
    s.o.busy = 1'b1; s.o.pc_load = 1'b1; s.o.pc_out = 10'(tgt);
    s.o.err_to = to; s.o.err_ill = !(waits || direct);
    if (!to && (alu || (opi == 29) || (opi == 26))) begin
      s.o.wb_en  = 1'b1;
      s.o.wb_sel = alu ? 2'd0 : ((opi == 29) ? 2'd1 : 2'd2);
    end
    tl_q.push_back(s);
  endfunction

  // Per-cycle comparison against the model; idle vector when nothing queued.
  always @(negedge clk) begin : compare
    step_t e;
    obs_t  a;
    if (chk_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
      end else begin
        e.o = '0; e.o.ready = 1'b1; e.pd = '0;
      end
      a.ready = bus.instr_ready;   a.busy = bus.busy;
      a.alu_en = bus.alu_enable;   a.push_req = bus.push_req;
      a.pop_req = bus.pop_req;     a.wb_en = bus.wb_en;
      a.wb_sel = bus.wb_sel;       a.pc_load = bus.pc_load;
      a.pc_out = bus.pc_out;       a.err_to = bus.err_timeout;
      a.err_ill = bus.err_illegal;
      chk("cycle_outputs{rdy,busy,alu,push,pop,wb,sel,ld,pc,to,ill}", 32'(a), 32'(e.o));
      if (e.o.push_req) chk("push_data", 32'(bus.push_data), 32'(e.pd));
      if (bus.pc_load === 1'b1) begin
        last_pc = int'(bus.pc_out); last_wb = int'(bus.wb_en);
        last_wbsel = int'(bus.wb_sel); last_to = int'(bus.err_timeout);
        last_ill = int'(bus.err_illegal);
      end
      if (bus.push_req === 1'b1) last_pd = int'(bus.push_data);
    end
  end

  // Issue one instruction from an IDLE cycle and play the done response.
  // rst_after > 0 pulses reset after that many wait cycles instead.
  task automatic run(input logic [5:0] op, input logic [9:0] pc, input logic [15:0] imm,
                     input logic [3:0] flg, input int d, input logic [15:0] popv,
                     input int rst_after);
    build(op, pc, imm, flg, d, popv);
    last_pc = -1; last_wb = 0; last_wbsel = 0; last_pd = -1; last_to = 0; last_ill = 0;
    {bus.fl_zero, bus.fl_negative, bus.fl_carry, bus.fl_overflow} = flg;
    bus.instruction = {op, 10'($urandom)};
    bus.pc = pc;
    bus.imm = imm;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    if (rst_after > 0) begin
      for (int i = 0; i <= rst_after; i++) exp_q.push_back(tl_q[i]);
      repeat (rst_after) @(posedge clk);
      #1 rst_b = 1'b1;
      @(posedge clk); #1;
      rst_b = 1'b0;
    end else begin
      foreach (tl_q[i]) exp_q.push_back(tl_q[i]);
      if ((w_model > 0) && (d > 0)) begin
        repeat (d) @(posedge clk); #1;
        if (op <= 6'd17) bus.alu_done = 1'b1;
        else if ((op == 6'd28) || (op == 6'd37)) bus.push_done = 1'b1;
        else begin bus.pop_done = 1'b1; bus.pop_out = popv; end
        @(posedge clk); #1;
        bus.alu_done = 1'b0; bus.push_done = 1'b0; bus.pop_done = 1'b0;
        bus.pop_out = 16'hFFFF;
        @(posedge clk); #1;
      end else begin
        repeat (w_model + 2) @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    bus.instr_valid = 1'b0; bus.instruction = '0; bus.pc = '0; bus.imm = '0;
    bus.fl_zero = 1'b0; bus.fl_negative = 1'b0; bus.fl_carry = 1'b0; bus.fl_overflow = 1'b0;
    bus.alu_done = 1'b0; bus.push_done = 1'b0; bus.pop_done = 1'b0; bus.pop_out = '0;
    repeat (3) @(posedge clk); #1;
    rst_b = 1'b0;
    chk("rst_ready", 32'(bus.instr_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk_en = 1'b1;

    run(6'd0, 10'd5, 16'h0000, 4'b0000, 3, 16'h0, 0);          // ADD, done 3 after enable
    chk("add_pc", last_pc, 32'd6);
    chk("add_wb", last_wb, 32'd1);
    chk("add_sel", last_wbsel, 32'd0);

    run(6'd32, 10'h010, 16'h0120, 4'b1000, 0, 16'h0, 0);       // BRZ taken
    chk("brz_taken_pc", last_pc, 32'h120);
    run(6'd32, 10'h0A0, 16'h0120, 4'b0000, 0, 16'h0, 0);       // BRZ not taken
    chk("brz_fall_pc", last_pc, 32'h0A1);

    run(6'd37, 10'h3FF, 16'h0040, 4'b0000, 2, 16'h0, 0);       // JMP at 1023
    chk("jmp_push_data", last_pd, 32'h0000);
    chk("jmp_pc", last_pc, 32'h040);

    run(6'd38, 10'h050, 16'h0000, 4'b0000, 4, 16'h0155, 0);    // RET
    chk("ret_pc", last_pc, 32'h155);
    chk("ret_no_wb", last_wb, 32'd0);

    bus.alu_done = 1'b1; bus.push_done = 1'b1;                  // foreign dones ignored
    run(6'd29, 10'h200, 16'h0000, 4'b0000, 0, 16'h0, 0);       // POP timeout
    bus.alu_done = 1'b0; bus.push_done = 1'b0;
    chk("pop_timeout_flag", last_to, 32'd1);
    chk("pop_timeout_pc", last_pc, 32'h201);

    run(6'd28, 10'h007, 16'hBEEF, 4'b0000, 1, 16'h0, 0);       // PUSH
    chk("push_data_imm", last_pd, 32'hBEEF);
    run(6'd29, 10'h123, 16'h0000, 4'b0000, 15, 16'h1234, 0);   // POP done on last wait
    chk("pop_late_sel", last_wbsel, 32'd1);
    chk("pop_late_to", last_to, 32'd0);
    run(6'd26, 10'h3FE, 16'h5A5A, 4'b0000, 0, 16'h0, 0);       // INP
    chk("inp_sel", last_wbsel, 32'd2);
    run(6'd45, 10'h3FF, 16'h0000, 4'b0000, 0, 16'h0, 0);       // illegal, pc wraps
    chk("illegal_flag", last_ill, 32'd1);
    chk("illegal_pc", last_pc, 32'h000);
    run(6'd20, 10'h030, 16'h0000, 4'b0000, 0, 16'h0, 0);
    run(6'd33, 10'h031, 16'h0333, 4'b0100, 0, 16'h0, 0);       // BRN taken
    run(6'd34, 10'h032, 16'h0334, 4'b1101, 0, 16'h0, 0);       // BRC not taken
    run(6'd35, 10'h033, 16'h0335, 4'b0001, 0, 16'h0, 0);       // BRO taken
    run(6'd36, 10'h034, 16'h0336, 4'b0000, 0, 16'h0, 0);       // BRA
    chk("bra_pc", last_pc, 32'h336);
    bus.pop_done = 1'b1;
    run(6'd17, 10'h040, 16'h0000, 4'b0000, 0, 16'h0, 0);       // ALU timeout
    bus.pop_done = 1'b0;
    chk("alu_timeout_wb", last_wb, 32'd0);
    run(6'd18, 10'h041, 16'h0000, 4'b0000, 0, 16'h0, 0);
    run(6'd27, 10'h042, 16'h0000, 4'b0000, 0, 16'h0, 0);

    run(6'd28, 10'h010, 16'h1111, 4'b0000, 0, 16'h0, 3);       // reset in PUSH_WAIT
    chk("rst_no_pc_load", last_pc, 32'hFFFF_FFFF);
    chk("rst_push_req", 32'(bus.push_req), 32'd0);
    run(6'd1, 10'h011, 16'h0000, 4'b0000, 1, 16'h0, 0);        // recovers after reset
    chk("post_rst_pc", last_pc, 32'h012);

    repeat (3) @(posedge clk); #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
